// File: rtl/alu16_seq.sv
// alu16_seq: sequences 16-bit D-register arithmetic (ADDD/SUBD/CMPD/LDD/STD)
// over the shared 8-bit ALU, low byte first, chaining carry/borrow into the
// high byte and merging the per-byte flags into 16-bit condition codes.
// Narrow (8-bit) operations take a single ALU cycle.
// Optional feature macro: M6809_ALU16_SEQ_ERR_EN (rejects illegal wide ops).
module alu16_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        wide,
  input  logic [3:0]  op,
  input  logic        op7,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [3:0]  cc_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  cc_out,
  output logic        wr_en,
  output logic        err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_op7,
  output logic        alu_c,
  input  logic [7:0]  alu_out,
  input  logic        alu_c_out,
  input  logic        alu_z_out,
  input  logic        alu_n_out,
  input  logic        alu_v_out
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  op_reg;
  logic        op7_reg, wide_reg, c_in_reg;
  logic [15:0] opa_reg, opb_reg;
  logic [7:0]  lo_res;
  logic        lo_c, lo_z;
  logic        is_add, is_subcmp, is_ldst, wr_flag, reject;
  logic [3:0]  lo_cc, hi_cc;

  // Decode of the latched operation class
  assign is_add    = (op_reg == 4'hb);
  assign is_subcmp = ((op_reg == 4'h0) && op7_reg) || (op_reg == 4'h1);
  assign is_ldst   = ((op_reg == 4'h6) || (op_reg == 4'h7)) && op7_reg;
  assign wr_flag   = !((op_reg == 4'h1) || (op_reg == 4'h5));

`ifdef M6809_ALU16_SEQ_ERR_EN
  // A wide op outside ADD/SUB/CMP/LD/ST is refused at accept time
  assign reject = wide && !((op == 4'hb) || ((op == 4'h0) && op7) || (op == 4'h1) ||
                            (((op == 4'h6) || (op == 4'h7)) && op7));

  // err pulses in the DONE cycle of a refused op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= (state_reg == IDLE) && start && reject;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  // Single-byte flags straight from the ALU
  assign lo_cc = {alu_n_out, alu_z_out, alu_v_out, alu_c_out};

  // Wide flag merge: Z spans both bytes, C converted back to 6809 borrow for SUB/CMP
  always_comb begin
    hi_cc[3] = alu_n_out;
    hi_cc[2] = lo_z & alu_z_out;
    hi_cc[1] = is_ldst ? 1'b0 : alu_v_out;
    if (is_add)         hi_cc[0] = alu_c_out;
    else if (is_subcmp) hi_cc[0] = ~alu_c_out;
    else if (is_ldst)   hi_cc[0] = c_in_reg;
    else                hi_cc[0] = alu_c_out;
  end

  // Next-state and ALU port decode
  always_comb begin
    state_next = state_reg;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_op     = 4'hd;
    alu_op7    = 1'b0;
    alu_c      = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = reject ? DONE : LO;
      LO: begin
        state_next = wide_reg ? HI : DONE;
        alu_a      = opa_reg[7:0];
        alu_b      = opb_reg[7:0];
        alu_op     = op_reg;
        alu_op7    = op7_reg;
        alu_c      = c_in_reg;
      end
      HI: begin
        state_next = DONE;
        alu_a      = opa_reg[15:8];
        alu_b      = opb_reg[15:8];
        if (is_add) begin
          alu_op  = 4'h9;
          alu_op7 = 1'b1;
          alu_c   = lo_c;
        end else if (is_subcmp) begin
          alu_op  = 4'h2;
          alu_op7 = 1'b1;
          alu_c   = ~lo_c;
        end else begin
          alu_op  = op_reg;
          alu_op7 = op7_reg;
          alu_c   = c_in_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand latches, per-byte results and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 16'h0000;
      cc_out    <= 4'h0;
      wr_en     <= 1'b0;
      op_reg    <= 4'h0;
      op7_reg   <= 1'b0;
      wide_reg  <= 1'b0;
      c_in_reg  <= 1'b0;
      opa_reg   <= 16'h0000;
      opb_reg   <= 16'h0000;
      lo_res    <= 8'h00;
      lo_c      <= 1'b0;
      lo_z      <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      case (state_reg)
        IDLE: if (start) begin
          op_reg   <= op;
          op7_reg  <= op7;
          wide_reg <= wide;
          c_in_reg <= cc_in[0];
          opa_reg  <= opa;
          opb_reg  <= opb;
          if (reject) begin
            result <= opa;
            cc_out <= cc_in;
            wr_en  <= 1'b0;
          end
        end
        LO: begin
          lo_res <= alu_out;
          lo_c   <= alu_c_out;
          lo_z   <= alu_z_out;
          if (!wide_reg) begin
            result <= {8'h00, alu_out};
            cc_out <= lo_cc;
            wr_en  <= wr_flag;
          end
        end
        HI: begin
          result <= {alu_out, lo_res};
          cc_out <= hi_cc;
          wr_en  <= wr_flag;
        end
        default: ;
      endcase
    end
  end

endmodule
